parallel_to_serial: RTL and testbench
=====================================

PARALLEL_TO_SERIAL -- requirements
Module: parallel_to_serial

Interface
REQ-001 The block SHALL have this parameter: DATA_WIDTH, default 8, word width in bits; legal range 2..32.
REQ-002 The block SHALL have this port: clk  input  1  single clock; all logic on its rising edge.
REQ-003 The block SHALL have this port: rst  input  1  reset; synchronous and active-high.
REQ-004 The block SHALL have this port: in_valid  input  1  in_data holds a word to be sent.
REQ-005 The block SHALL have this port: in_data  input  DATA_WIDTH  parallel word to serialize.
REQ-006 The block SHALL have this port: in_ready  output  1  block can accept a word this cycle.
REQ-007 The block SHALL have this port: bit_en  input  1  bit strobe; a bit is emitted only in cycles where it is high.
REQ-008 The block SHALL have this port: serial_valid  output  1  serial_data carries a valid bit this cycle.
REQ-009 The block SHALL have this port: serial_data  output  1  serialized bit stream.
REQ-010 The block SHALL have this port: frame_last  output  1  high with the final bit of a word.
REQ-011 The block SHALL have this port: busy  output  1  a word is loaded and not yet fully emitted.

Function
REQ-012 The block SHALL accept a word on a rising edge where in_valid and in_ready are both high; in_data is captured into the shift register at that edge.
REQ-013 The FSM SHALL have two states: IDLE (no word loaded) and SHIFT (word loaded).
- IDLE -> SHIFT on accept.
- SHIFT -> IDLE after the last bit, unless a follow-on word is loaded (REQ-024).
REQ-014 Bits SHALL be emitted LSB first (in_data[0] first, in_data[DATA_WIDTH-1] last), so a shift-in-from-MSB receiver rebuilds the word unchanged.
REQ-015 In SHIFT, serial_valid and serial_data SHALL be registered outputs.
- serial_valid SHALL equal bit_en registered.
- When bit_en is low, serial_valid SHALL be low and serial_data SHALL hold its value.
REQ-016 Minimum latency SHALL be one cycle: with bit_en held high, the word accepted at edge N produces bit 0 valid in the cycle after edge N+1.
REQ-017 A bit counter SHALL count emitted bits from 0 to DATA_WIDTH-1 and wrap to 0 after the last bit; it SHALL never exceed DATA_WIDTH-1.
REQ-018 frame_last SHALL be high only in the cycle carrying bit DATA_WIDTH-1 with serial_valid high.
REQ-019 busy SHALL be high whenever the FSM is in SHIFT.
REQ-020 Outside SHIFT, serial_valid and frame_last SHALL be 0 and serial_data SHALL be 0.
REQ-021 If in_valid is high while in_ready is low, the word SHALL NOT be captured; the sender SHALL hold it, and a dropped handshake SHALL NOT corrupt the in-flight word.
REQ-022 in_ready SHALL depend only on internal state, never combinationally on in_valid.

Reset
REQ-023 When rst is high at a rising edge, the block SHALL clear the FSM to IDLE, the counter to 0, the shift register to 0, and serial_valid, serial_data, frame_last and busy to 0; this includes reset mid-word, which aborts the word with no further bits emitted; in_ready SHALL be 0 while rst is high and SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-024 Macro P2S_HOLD_BUF_EN SHALL select the input buffering.
- Defined: a one-word holding register SHALL be present, and in_ready SHALL be high when the holding register is empty. At the last-bit edge, a held word SHALL load directly into the shift register so the next word's bit 0 follows with no gap (continuous stream). An accept coinciding with the last-bit edge while holding is empty SHALL also load without a gap.
- Undefined: no holding register SHALL be present, and in_ready SHALL be high only in IDLE. At least one idle cycle SHALL separate consecutive words.

Verification
REQ-025 The bench SHALL cover single word: reset, bit_en=1, send 8'hA5, and SHALL require serial bits 1,0,1,0,0,1,0,1 on 8 consecutive valid cycles, frame_last on the 8th only, and busy low afterward.
REQ-026 The bench SHALL cover gated strobe: send 8'h81 with bit_en toggling 1,0,1,0..., and SHALL require exactly 8 valid cycles, each followed by an invalid cycle, data 1,0,0,0,0,0,0,1, with serial_data held during gaps.
REQ-027 The bench SHALL cover back-to-back traffic: in_valid held high with 8'h0F, then 8'hF0. With P2S_HOLD_BUF_EN, it SHALL require 16 contiguous valid bits. Without it, it SHALL require at least one invalid cycle between the words.
REQ-028 The bench SHALL cover backpressure: assert in_valid with 8'h3C while busy, and SHALL require that the word is not captured until in_ready is high and that the in-flight word is emitted intact.
REQ-029 The bench SHALL cover reset mid-word: assert rst after bit 3 of 8'hFF, and SHALL require all outputs 0 on the next cycle and a subsequent 8'h01 serialized correctly from bit 0.
REQ-030 The bench SHALL cover DATA_WIDTH=2 and DATA_WIDTH=32: send all-ones and alternating patterns, and SHALL require correct bit order, frame_last on bit DATA_WIDTH-1 and correct counter wrap.

Source files
------------

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: loads a DATA_WIDTH-bit word and shifts it out LSB first,
// one bit per cycle in which bit_en is high.
// Optional feature: define P2S_HOLD_BUF_EN to add a one-word holding register
// that lets consecutive words stream with no idle gap between them.
//
// Handshake: a word transfers on a rising edge where in_valid && in_ready.
// in_ready is a function of internal state and rst only, never of in_valid.
// A sender that sees in_ready low keeps in_valid and in_data stable.
//
// FSM: IDLE (no word loaded) / SHIFT (word loaded).
// Leaving SHIFT happens at the edge that emits the final bit, so the cycle
// that carries the final bit (registered output) already shows busy low.
module parallel_to_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  bit_en,
    output logic                  serial_valid,
    output logic                  serial_data,
    output logic                  frame_last,
    output logic                  busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CW-1:0]         bit_cnt;
    logic                  accept;
    logic                  last_bit;

`ifdef P2S_HOLD_BUF_EN
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] hold_data;

    // Ready whenever the holding register can take a word.
    assign in_ready = !rst && !hold_valid;
`else
    // Without buffering a new word is only taken when nothing is loaded.
    assign in_ready = !rst && (state == IDLE);
`endif

    assign accept   = in_valid && in_ready;
    assign last_bit = (state == SHIFT) && bit_en && (bit_cnt == LAST_IDX);
    assign busy     = (state == SHIFT);

    // FSM, bit counter, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            serial_valid <= 1'b0;
            serial_data  <= 1'b0;
            frame_last   <= 1'b0;
`ifdef P2S_HOLD_BUF_EN
            hold_valid   <= 1'b0;
            hold_data    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    serial_valid <= 1'b0;
                    serial_data  <= 1'b0;
                    frame_last   <= 1'b0;
                    bit_cnt      <= '0;
                    if (accept) begin
                        shift_reg <= in_data;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    // serial_valid is bit_en delayed one cycle; data holds in gaps.
                    serial_valid <= bit_en;
                    frame_last   <= last_bit;
                    if (bit_en) begin
                        serial_data <= shift_reg[0];
                        if (last_bit) begin
                            bit_cnt <= '0;
`ifdef P2S_HOLD_BUF_EN
                            // Chain the next word straight in so bit 0 follows without a gap.
                            if (hold_valid) begin
                                shift_reg  <= hold_data;
                                hold_valid <= 1'b0;
                            end else if (accept) begin
                                shift_reg <= in_data;
                            end else begin
                                shift_reg <= '0;
                                state     <= IDLE;
                            end
`else
                            shift_reg <= '0;
                            state     <= IDLE;
`endif
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg >> 1;
                        end
                    end
`ifdef P2S_HOLD_BUF_EN
                    // A word arriving mid-frame parks in the holding register.
                    if (accept && !last_bit) begin
                        hold_data  <= in_data;
                        hold_valid <= 1'b1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed testbench for parallel_to_serial at DATA_WIDTH 8, 2 and 32.
// Follows P2S_HOLD_BUF_EN for the expectations that depend on buffering.
module tb_parallel_to_serial;

    logic clk = 1'b0;
    logic rst;
    logic bit_en;

    logic        v8, r8, sv8, sd8, fl8, b8;
    logic [7:0]  d8;
    logic        v2, r2, sv2, sd2, fl2, b2;
    logic [1:0]  d2;
    logic        v32, r32, sv32, sd32, fl32, b32;
    logic [31:0] d32;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int accept_cyc;

    logic bq8[$];
    logic lq8[$];
    int   cq8[$];
    logic bq2[$];
    logic lq2[$];
    logic bq32[$];
    logic lq32[$];

    parallel_to_serial #(.DATA_WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .in_valid(v8), .in_data(d8), .in_ready(r8),
        .bit_en(bit_en), .serial_valid(sv8), .serial_data(sd8),
        .frame_last(fl8), .busy(b8)
    );

    parallel_to_serial #(.DATA_WIDTH(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_data(d2), .in_ready(r2),
        .bit_en(bit_en), .serial_valid(sv2), .serial_data(sd2),
        .frame_last(fl2), .busy(b2)
    );

    parallel_to_serial #(.DATA_WIDTH(32)) u32 (
        .clk(clk), .rst(rst), .in_valid(v32), .in_data(d32), .in_ready(r32),
        .bit_en(bit_en), .serial_valid(sv32), .serial_data(sd32),
        .frame_last(fl32), .busy(b32)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // output monitors: record every valid bit at the falling edge
    always @(negedge clk) begin
        if (sv8 === 1'b1) begin
            bq8.push_back(sd8);
            lq8.push_back(fl8);
            cq8.push_back(cyc);
        end
        if (sv2 === 1'b1) begin
            bq2.push_back(sd2);
            lq2.push_back(fl2);
        end
        if (sv32 === 1'b1) begin
            bq32.push_back(sd32);
            lq32.push_back(fl32);
        end
    end

    function automatic logic ready_of(input int which);
        case (which)
            2:       return r2;
            32:      return r32;
            default: return r8;
        endcase
    endfunction

    function automatic logic idle_of(input int which);
        case (which)
            2:       return !b2 && !sv2;
            32:      return !b32 && !sv32;
            default: return !b8 && !sv8;
        endcase
    endfunction

    task automatic clear_queues();
        bq8.delete(); lq8.delete(); cq8.delete();
        bq2.delete(); lq2.delete();
        bq32.delete(); lq32.delete();
    endtask

    // driver: call at a falling edge; returns at the falling edge after the accept
    task automatic send_word(input int which, input logic [31:0] d, input bit keep);
        bit ok;
        ok = 1'b0;
        case (which)
            2:       begin v2 = 1'b1;  d2 = d[1:0]; end
            32:      begin v32 = 1'b1; d32 = d;     end
            default: begin v8 = 1'b1;  d8 = d[7:0]; end
        endcase
        for (int n = 0; n < 200; n++) begin
            if (ready_of(which) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
            accept_cyc = cyc;
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL send_word_timeout width=%0d data=%h: in_ready never high", which, d);
        end
        if (!keep) begin
            case (which)
                2:       v2 = 1'b0;
                32:      v32 = 1'b0;
                default: v8 = 1'b0;
            endcase
        end
    endtask

    task automatic wait_idle(input int which);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (idle_of(which) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_idle width=%0d: still busy after 300 cycles", which);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; bit_en = 1'b0;
        v8 = 1'b0; d8 = '0; v2 = 1'b0; d2 = '0; v32 = 1'b0; d32 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({r8, r2, r32} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ready_low got=%b exp=000", {r8, r2, r32});
        end
        n_checks++;
        if ({sv8, sd8, fl8, b8} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0000", {sv8, sd8, fl8, b8});
        end
        n_checks++;
        if ({sv32, sd32, fl32, b32, sv2, sd2, fl2, b2} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs_w2_w32 got=%b exp=00000000",
                     {sv32, sd32, fl32, b32, sv2, sd2, fl2, b2});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({r8, r2, r32} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_release_ready got=%b exp=111", {r8, r2, r32});
        end
    endtask

    task automatic test_single_word();
        logic [7:0] exp_w;
        exp_w = 8'hA5;
        clear_queues();
        bit_en = 1'b1;
        send_word(8, 32'hA5, 1'b0);
        wait_idle(8);
        n_checks++;
        if (bq8.size() != 8) begin
            n_fail++;
            $display("FAIL single_count got=%0d exp=8", bq8.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (bq8[i] !== exp_w[i] || lq8[i] !== (i == 7) || cq8[i] != cq8[0] + i) begin
                    n_fail++;
                    $display("FAIL single_bit%0d got=%b/%b/cyc%0d exp=%b/%b/cyc%0d", i, bq8[i], lq8[i],
                             cq8[i], exp_w[i], (i == 7), cq8[0] + i);
                end
            end
            n_checks++;
            if (cq8[0] != accept_cyc + 1) begin
                n_fail++;
                $display("FAIL single_latency got=%0d exp=%0d", cq8[0], accept_cyc + 1);
            end
        end
        n_checks++;
        if ({b8, sv8, fl8} !== 3'b000) begin
            n_fail++;
            $display("FAIL single_after got=%b exp=000", {b8, sv8, fl8});
        end
    endtask

    task automatic test_gated_strobe();
        logic [7:0] exp_w;
        logic       sv[20];
        logic       sd[20];
        logic       fl[20];
        int         nv;
        exp_w = 8'h81;
        bit_en = 1'b0;
        send_word(8, 32'h81, 1'b0);
        bit_en = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            sv[j] = sv8; sd[j] = sd8; fl[j] = fl8;
            bit_en = ~bit_en;
        end
        nv = 0;
        for (int j = 0; j < 20; j++) if (sv[j] === 1'b1) nv++;
        n_checks++;
        if (nv != 8) begin
            n_fail++;
            $display("FAIL gated_valid_count got=%0d exp=8", nv);
        end
        for (int j = 0; j < 16; j++) begin
            n_checks++;
            if (j % 2 == 0) begin
                if (sv[j] !== 1'b1 || sd[j] !== exp_w[j/2] || fl[j] !== (j == 14)) begin
                    n_fail++;
                    $display("FAIL gated_bit%0d got=%b%b%b exp=1%b%b", j/2, sv[j], sd[j], fl[j],
                             exp_w[j/2], (j == 14));
                end
            end else if (j < 15) begin
                if (sv[j] !== 1'b0 || sd[j] !== sd[j-1] || fl[j] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL gated_gap%0d got=%b%b%b exp=0%b0", j, sv[j], sd[j], fl[j], sd[j-1]);
                end
            end else if (sv[j] !== 1'b0) begin
                n_fail++;
                $display("FAIL gated_tail got=%b exp=0", sv[j]);
            end
        end
        bit_en = 1'b1;
        wait_idle(8);
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_s;
        exp_s = 16'hF00F;
        clear_queues();
        bit_en = 1'b1;
        send_word(8, 32'h0F, 1'b1);
        send_word(8, 32'hF0, 1'b0);
        wait_idle(8);
        n_checks++;
        if (bq8.size() != 16) begin
            n_fail++;
            $display("FAIL b2b_count got=%0d exp=16", bq8.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (bq8[i] !== exp_s[i] || lq8[i] !== (i == 7 || i == 15)) begin
                    n_fail++;
                    $display("FAIL b2b_bit%0d got=%b/%b exp=%b/%b", i, bq8[i], lq8[i], exp_s[i],
                             (i == 7 || i == 15));
                end
            end
            n_checks++;
`ifdef P2S_HOLD_BUF_EN
            if (cq8[15] != cq8[0] + 15) begin
                n_fail++;
                $display("FAIL b2b_contiguous got_span=%0d exp=15", cq8[15] - cq8[0]);
            end
`else
            if (cq8[8] <= cq8[7] + 1) begin
                n_fail++;
                $display("FAIL b2b_gap got_gap=%0d exp>=2", cq8[8] - cq8[7]);
            end
`endif
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_s;
        exp_s = 16'h3CC3;
        clear_queues();
        bit_en = 1'b1;
        send_word(8, 32'hC3, 1'b0);
        v8 = 1'b1; d8 = 8'h3C;
        n_checks++;
`ifdef P2S_HOLD_BUF_EN
        if (r8 !== 1'b1 || b8 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_busy got=%b%b exp=11", r8, b8);
        end
`else
        if (r8 !== 1'b0 || b8 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_busy got=%b%b exp=01", r8, b8);
        end
`endif
        send_word(8, 32'h3C, 1'b0);
`ifdef P2S_HOLD_BUF_EN
        n_checks++;
        if (r8 !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold_full_ready got=%b exp=0", r8);
        end
`endif
        wait_idle(8);
        n_checks++;
        if (bq8.size() != 16) begin
            n_fail++;
            $display("FAIL bp_count got=%0d exp=16", bq8.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_checks++;
                if (bq8[i] !== exp_s[i] || lq8[i] !== (i == 7 || i == 15)) begin
                    n_fail++;
                    $display("FAIL bp_bit%0d got=%b/%b exp=%b/%b", i, bq8[i], lq8[i], exp_s[i],
                             (i == 7 || i == 15));
                end
            end
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] exp_w;
        bit         ok;
        exp_w = 8'h01;
        ok = 1'b0;
        clear_queues();
        bit_en = 1'b1;
        send_word(8, 32'hFF, 1'b0);
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bq8.size() >= 4) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midrst_bits got=%0d exp=4", bq8.size());
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({sv8, sd8, fl8, b8, r8} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrst_outputs got=%b exp=00000", {sv8, sd8, fl8, b8, r8});
        end
        rst = 1'b0;
        clear_queues();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bq8.size() != 0 || r8 !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_abort got_bits=%0d ready=%b exp_bits=0 ready=1", bq8.size(), r8);
        end
        send_word(8, 32'h01, 1'b0);
        wait_idle(8);
        n_checks++;
        if (bq8.size() != 8) begin
            n_fail++;
            $display("FAIL midrst_next_count got=%0d exp=8", bq8.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_checks++;
                if (bq8[i] !== exp_w[i] || lq8[i] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL midrst_next_bit%0d got=%b/%b exp=%b/%b", i, bq8[i], lq8[i],
                             exp_w[i], (i == 7));
                end
            end
        end
    endtask

    task automatic test_width_2();
        logic [3:0] exp_s;
        exp_s = 4'b1011;
        clear_queues();
        bit_en = 1'b1;
        send_word(2, 32'h3, 1'b0);
        send_word(2, 32'h2, 1'b0);
        wait_idle(2);
        n_checks++;
        if (bq2.size() != 4) begin
            n_fail++;
            $display("FAIL w2_count got=%0d exp=4", bq2.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (bq2[i] !== exp_s[i] || lq2[i] !== (i == 1 || i == 3)) begin
                    n_fail++;
                    $display("FAIL w2_bit%0d got=%b/%b exp=%b/%b", i, bq2[i], lq2[i], exp_s[i],
                             (i == 1 || i == 3));
                end
            end
        end
    endtask

    task automatic test_width_32();
        logic [63:0] exp_s;
        exp_s = 64'hAAAAAAAA_FFFFFFFF;
        clear_queues();
        bit_en = 1'b1;
        send_word(32, 32'hFFFFFFFF, 1'b0);
        send_word(32, 32'hAAAAAAAA, 1'b0);
        wait_idle(32);
        n_checks++;
        if (bq32.size() != 64) begin
            n_fail++;
            $display("FAIL w32_count got=%0d exp=64", bq32.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                n_checks++;
                if (bq32[i] !== exp_s[i] || lq32[i] !== (i == 31 || i == 63)) begin
                    n_fail++;
                    $display("FAIL w32_bit%0d got=%b/%b exp=%b/%b", i, bq32[i], lq32[i], exp_s[i],
                             (i == 31 || i == 63));
                end
            end
        end
    endtask

    // test sequence and final report
    initial begin
        test_reset();
        test_single_word();
        test_gated_strobe();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_word();
        test_width_2();
        test_width_32();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
